fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one circular FIFO (DEPTH entries, WIDTH bits) among NREQ producers.
It picks one requester per cycle, registers that requester's word onto the FIFO write port and tracks FIFO occupancy with a credit counter, so the FIFO never receives a write while full.
Credits return on every successful FIFO read.
Sits directly in front of the FIFO write port; the consumer drives the FIFO read port and mirrors it into this block.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, data width per word, equal to FIFO width
DEPTH, 16, FIFO depth in entries, equal to FIFO depth
CW, $clog2(DEPTH+1), credit counter width
IW, $clog2(NREQ), grant index width (minimum 1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-low reset
req  input  NREQ  per-requester level request; bit i high = requester i holds a valid word
req_data  input  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
ack  output  NREQ  combinational one-hot accept; word i consumed at this clock edge
fifo_rd  input  1  FIFO read strobe, mirrored from consumer
fifo_empty  input  1  FIFO empty flag
fifo_wr  output  1  registered write strobe to FIFO
fifo_wr_data  output  WIDTH  registered write data to FIFO
gnt_id  output  IW  registered index of requester behind current fifo_wr
credits  output  CW  free FIFO entries as seen by arbiter

Behaviour:
- One clock (clk); reset rst is synchronous and active-low. All state changes on rising clk only.
- Reset values (rst=0 at an edge):
  - fifo_wr=0, fifo_wr_data=0, gnt_id=0
  - credits=DEPTH
  - rr_last=NREQ-1, so requester 0 has top priority after reset
- ack is forced to 0 while rst=0.
- The FIFO must be reset in the same cycle as this block.
- Grant (combinational, each cycle):
  - Eligible when rst=1, credits!=0 and |req.
  - Winner = first i with req[i]=1, searching from (rr_last+1) mod NREQ upward with wrap.
  - ack = one-hot of the winner when eligible, otherwise 0.
- Edge after a grant:
  - fifo_wr=1
  - fifo_wr_data = req_data word of the winner
  - gnt_id = winner
  - rr_last = winner
- Edge with no grant: fifo_wr=0; fifo_wr_data, gnt_id and rr_last hold.
- Latency: the word is accepted in cycle t and the FIFO writes it at the end of cycle t+1.
  - Credits are debited at the grant, so the one-cycle write lag can never overflow the FIFO.
- Producer handshake:
  - req/req_data must stay stable until ack.
  - A producer may present its next word in the cycle after ack by keeping req high.
  - Back-to-back grants to the same requester are legal when it is the only requester.
- Credits:
  - pop = fifo_rd & !fifo_empty
  - credits_next = credits - grant + pop
  - grant and pop in the same cycle leave credits unchanged.
- Boundaries:
  - credits==0: no ack even if pop=1 in that cycle; grant resumes the next cycle.
  - credits==DEPTH with pop=1 is a protocol error; saturate at DEPTH.
  - Grant never occurs at credits==0, so credits never underflow.
- Fairness: with all NREQ requesting continuously, grant order is 0,1,...,NREQ-1,0,... with one grant per cycle while credits remain.
- Reset mid-operation: any pending fifo_wr is dropped and the word is lost; credits return to DEPTH.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined, adds output grant_cnt, width NREQ*16.
  - Requester i has a 16-bit counter at bits [i*16 +: 16].
  - The counter increments on each edge where ack[i]=1 and wraps 0xFFFF->0.
  - All counters reset to 0.
- When undefined, the port and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset, then req=4'b0001, data0=0xA5 for 1 cycle -> ack=0001 in the same cycle; next cycle fifo_wr=1, fifo_wr_data=0xA5, gnt_id=0; credits 16->15.
- req=4'b1111 held for 8 cycles, no reads -> ack order 0,1,2,3,0,1,2,3; credits=8; FIFO holds data in that order.
- Single requester held high for 20 cycles, no reads -> exactly 16 acks; ack=0 from cycle 17 on; credits=0; FIFO full and never written while full.
- At credits=0 with req held, pulse fifo_rd for 1 cycle with FIFO non-empty -> no ack in that cycle; credits=1 next cycle; then one ack; credits back to 0.
- Grant and successful read in the same cycle at credits=5 -> credits stays 5.
- Assert rst=0 while fifo_wr=1 and credits=3 -> after the edge fifo_wr=0, credits=16, rr_last=3; next grant with req=1111 goes to requester 0.
- With FIFO_ARB_STATS_EN defined, run the 8-cycle round-robin scenario -> grant_cnt for each requester = 2.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NREQ producers, the write arbiter and the shared FIFO ports.
// The arbiter uses the slave modport; the producer/FIFO side uses master.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  fifo_rd;
  logic                  fifo_empty;
  logic                  fifo_wr;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic [IW-1:0]         gnt_id;
  logic [CW-1:0]         credits;

  modport master (
    output req, req_data, fifo_rd, fifo_empty,
    input  ack, fifo_wr, fifo_wr_data, gnt_id, credits
  );

  modport slave (
    input  req, req_data, fifo_rd, fifo_empty,
    output ack, fifo_wr, fifo_wr_data, gnt_id, credits
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with credit-based flow control in front of a shared FIFO.
// Optional per-requester grant counters are enabled with the FIFO_ARB_STATS_EN macro.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_wr_arbiter_if.slave     bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt
`endif
);

  logic [IW-1:0]    rr_last;
  logic [IW-1:0]    winner;
  logic             found;
  logic             grant;
  logic             pop;
  logic [CW-1:0]    credits_q;
  logic             fifo_wr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic [IW-1:0]    gnt_id_q;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(rr_last) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IW'((int'(rr_last) + k) % NREQ);
      end
    end
  end

  assign grant = rst && (credits_q != '0) && found;
  assign pop   = bus.fifo_rd & ~bus.fifo_empty;

  always_comb begin
    bus.ack = '0;
    if (grant) begin
      bus.ack[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_wr_q <= 1'b0;
      wr_data_q <= '0;
      gnt_id_q  <= '0;
      rr_last   <= IW'(NREQ - 1);
      credits_q <= CW'(DEPTH);
    end else begin
      fifo_wr_q <= grant;
      if (grant) begin
        wr_data_q <= bus.req_data[winner*WIDTH +: WIDTH];
        gnt_id_q  <= winner;
        rr_last   <= winner;
      end
      // Debit at grant time covers the word still in the output register.
      case ({grant, pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   if (credits_q != CW'(DEPTH)) credits_q <= credits_q + CW'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

  assign bus.fifo_wr      = fifo_wr_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.gnt_id       = gnt_id_q;
  assign bus.credits      = credits_q;

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i]) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
